// File: rtl/xm23_wb_regfile.sv
// XM23 writeback stage and architectural register file: one-entry pending
// writeback, R0-R7 commit, forwarding into bank 0, constant bank 1, R7 auto-increment.
module xm23_wb_regfile #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid_i,
    input  logic [2:0]            wb_dst_i,
    input  logic [15:0]           wb_result_i,
    input  logic                  flush_i,
    input  logic                  pc_adv_i,
    output logic [1:0][7:0][15:0] gprc,
    output logic [15:0]           pc_o,
    output logic                  wb_pend_o
);

    localparam logic [7:0][15:0] CONST_BANK = {
        16'hFFFF, 16'd32, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1, 16'd0
    };

    logic [7:0][15:0] regs;
    logic             pend_vld_p1;
    logic [2:0]       pend_dst_p1;
    logic [15:0]      pend_data_p1;
    logic             commit;

    // Stage 1: capture execute result into the pending entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_p1  <= 1'b0;
            pend_dst_p1  <= 3'd0;
            pend_data_p1 <= 16'h0000;
        end else begin
            pend_vld_p1 <= wb_valid_i & ~flush_i;
            if (wb_valid_i) begin
                pend_dst_p1  <= wb_dst_i;
                pend_data_p1 <= wb_result_i;
            end
        end
    end

    // Stage 2: commit pending entry; flush kills it on the same edge
    assign commit = pend_vld_p1 & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) begin
                regs[i] <= 16'h0000;
            end
            regs[7] <= RESET_PC;
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (commit && pend_dst_p1 == 3'(i)) begin
                    regs[i] <= pend_data_p1;
                end
            end
            // An explicit write to the PC wins over the fetch increment
            if (commit && pend_dst_p1 == 3'd7) begin
                regs[7] <= pend_data_p1;
            end else if (pc_adv_i) begin
                regs[7] <= regs[7] + PC_STEP;
            end
        end
    end

    always_comb begin
        gprc = '0;
        for (int i = 0; i < 8; i++) begin
            gprc[0][i] = (pend_vld_p1 && pend_dst_p1 == 3'(i)) ? pend_data_p1 : regs[i];
            gprc[1][i] = CONST_BANK[i];
        end
    end

    assign pc_o      = regs[7];
    assign wb_pend_o = pend_vld_p1;

endmodule

// File: tb/tb_xm23_wb_regfile.sv
// Scoreboard bench for xm23_wb_regfile: expectations are queued as each
// cycle's stimulus is driven and drained after the following rising edge.
module tb_xm23_wb_regfile;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  wb_valid_i = 1'b0;
    logic [2:0]            wb_dst_i = 3'd0;
    logic [15:0]           wb_result_i = 16'h0000;
    logic                  flush_i = 1'b0;
    logic                  pc_adv_i = 1'b0;
    logic [1:0][7:0][15:0] gprc;
    logic [15:0]           pc_o;
    logic                  wb_pend_o;

    xm23_wb_regfile #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid_i(wb_valid_i), .wb_dst_i(wb_dst_i),
        .wb_result_i(wb_result_i), .flush_i(flush_i), .pc_adv_i(pc_adv_i),
        .gprc(gprc), .pc_o(pc_o), .wb_pend_o(wb_pend_o)
    );

    always #5 clk = ~clk;

    // sel 0-7: bank 0 reg, 8-15: bank 1 entry, 16: pc_o, 17: wb_pend_o
    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_errors = 0;

    logic [7:0][15:0] m_regs;
    logic             m_pv;
    logic [2:0]       m_pd;
    logic [15:0]      m_pdata;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        if (sel < 8)       return gprc[0][sel];
        else if (sel < 16) return gprc[1][sel-8];
        else if (sel == 16) return pc_o;
        else               return {15'd0, wb_pend_o};
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic model_reset();
        m_regs = '0;
        m_pv = 1'b0; m_pd = 3'd0; m_pdata = 16'h0000;
    endtask

    // Drive one cycle of stimulus, advance the reference model, queue the
    // full observable state expected after the edge, then compare.
    task automatic step(input logic v, input logic [2:0] d, input logic [15:0] r,
                        input logic f, input logic a);
        logic [7:0][15:0] nr;
        logic             wr_pc;
        wb_valid_i = v; wb_dst_i = d; wb_result_i = r; flush_i = f; pc_adv_i = a;
        nr = m_regs;
        wr_pc = 1'b0;
        if (m_pv && !f) begin
            nr[m_pd] = m_pdata;
            wr_pc = (m_pd == 3'd7);
        end
        if (!wr_pc && a) nr[7] = m_regs[7] + 16'd2;
        m_regs = nr;
        m_pv = v && !f;
        if (v) begin
            m_pd = d; m_pdata = r;
        end
        for (int i = 0; i < 8; i++)
            expect_val($sformatf("bank0_r%0d", i), i,
                       (m_pv && m_pd == 3'(i)) ? m_pdata : m_regs[i]);
        expect_val("pc", 16, m_regs[7]);
        expect_val("pend", 17, {15'd0, m_pv});
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    endtask

    logic [15:0] consts [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0004,
                                16'h0008, 16'h0010, 16'h0020, 16'hFFFF};

    initial begin
        model_reset();
        // Reset state, observed while reset is held
        #3;
        for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), gprc[0][i], 16'h0000);
        for (int i = 0; i < 8; i++) check($sformatf("const%0d", i), gprc[1][i], consts[i]);
        check("rst_pc", pc_o, 16'h0000);
        check("rst_pend", {15'd0, wb_pend_o}, 16'h0000);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write forwarded, then committed
        expect_val("a5_fwd", 3, 16'hA5A5);
        expect_val("a5_pend", 17, 16'h0001);
        step(1'b1, 3'd3, 16'hA5A5, 1'b0, 1'b0);
        expect_val("a5_commit", 3, 16'hA5A5);
        expect_val("a5_pend_clr", 17, 16'h0000);
        idle();

        // Back-to-back writes to R2
        step(1'b1, 3'd2, 16'h1111, 1'b0, 1'b0);
        expect_val("r2_newest", 2, 16'h2222);
        step(1'b1, 3'd2, 16'h2222, 1'b0, 1'b0);
        expect_val("r2_array", 2, 16'h2222);
        idle();

        // Flush kills the pending R4 write
        step(1'b1, 3'd4, 16'h0F0F, 1'b0, 1'b0);
        expect_val("r4_flushed", 4, 16'h0000);
        expect_val("r4_pend", 17, 16'h0000);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        expect_val("r4_stays0", 4, 16'h0000);
        idle();

        // PC wrap
        step(1'b1, 3'd7, 16'hFFFC, 1'b0, 1'b0);
        expect_val("pc_load", 16, 16'hFFFC);
        idle();
        expect_val("pc_fffe", 16, 16'hFFFE);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
        expect_val("pc_wrap", 16, 16'h0000);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
        expect_val("pc_0002", 16, 16'h0002);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);

        // R7 commit suppresses increment
        step(1'b1, 3'd7, 16'h0400, 1'b0, 1'b0);
        expect_val("pc_commit", 16, 16'h0400);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
        expect_val("pc_0402", 16, 16'h0402);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);

        // Advance with flush still increments; valid input dropped
        expect_val("pc_adv_flush", 16, 16'h0404);
        expect_val("drop_pend", 17, 16'h0000);
        step(1'b1, 3'd1, 16'hBEEF, 1'b1, 1'b1);
        expect_val("r1_untouched", 1, 16'h0000);
        idle();

        // Random traffic against the model
        for (int k = 0; k < 60; k++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));

        // Asynchronous reset mid-cycle discards the pending entry
        step(1'b1, 3'd5, 16'h1234, 1'b0, 1'b0);
        check("pre_rst_pend", {15'd0, wb_pend_o}, 16'h0001);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) check($sformatf("arst_r%0d", i), gprc[0][i], 16'h0000);
        check("arst_pc", pc_o, 16'h0000);
        check("arst_pend", {15'd0, wb_pend_o}, 16'h0000);
        model_reset();
        wb_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_val("r5_never", 5, 16'h0000);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
